// File: rtl/urng_64.sv
// 64-bit combined Tausworthe uniform random number generator (three components).
// One new word per enabled clock, registered output with a one-cycle valid flag.
module urng_64 #(
  parameter logic [63:0] SEED0 = 64'h0123_4567_89AB_CDEF,
  parameter logic [63:0] SEED1 = 64'hFEDC_BA98_7654_3210,
  parameter logic [63:0] SEED2 = 64'h0F1E_2D3C_4B5A_6978
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  output logic [63:0] data_out,
  output logic        valid
);

  // Forced low-order bits keep every component above its lock-up region.
  localparam logic [63:0] SEED0_EFF = SEED0 | 64'd2;
  localparam logic [63:0] SEED1_EFF = SEED1 | 64'd512;
  localparam logic [63:0] SEED2_EFF = SEED2 | 64'd4096;

  localparam logic [63:0] MASK0 = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] MASK1 = 64'hFFFF_FFFF_FFFF_FE00;
  localparam logic [63:0] MASK2 = 64'hFFFF_FFFF_FFFF_F000;

  logic [63:0] s0, s1, s2;
  logic [63:0] b0, b1, b2;
  logic [63:0] s0_next, s1_next, s2_next;
  logic [63:0] y;

  // NOTE: combinational logic uses blocking '=' with every output assigned on
  // every path, so no latches are inferred; registers below use '<=' only.
  always_comb begin
    b0      = ((s0 << 1) ^ s0) >> 53;
    s0_next = ((s0 & MASK0) << 10) ^ b0;
    b1      = ((s1 << 24) ^ s1) >> 50;
    s1_next = ((s1 & MASK1) << 5) ^ b1;
    b2      = ((s2 << 3) ^ s2) >> 23;
    s2_next = ((s2 & MASK2) << 29) ^ b2;
    y       = s0_next ^ s1_next ^ s2_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0       <= SEED0_EFF;
      s1       <= SEED1_EFF;
      s2       <= SEED2_EFF;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        s0       <= s0_next;
        s1       <= s1_next;
        s2       <= s2_next;
        data_out <= y;
      end
    end
  end

endmodule

// File: tb/tb_urng_64.sv
// Self-checking bench for urng_64: directed vector table, asynchronous reset
// sequence, and a long gapped run against an equation model with bit statistics.
module tb_urng_64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en_s = 1'b0;
  logic        en_d = 1'b0;
  logic [63:0] dout_s, dout_z, dout_d;
  logic        valid_s, valid_z, valid_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Small seeds, zero seeds (must behave identically), and default seeds.
  urng_64 #(.SEED0(64'd2), .SEED1(64'd512), .SEED2(64'd4096)) u_small (
    .clk(clk), .rstn(rstn), .en(en_s), .data_out(dout_s), .valid(valid_s));
  urng_64 #(.SEED0(64'd0), .SEED1(64'd0), .SEED2(64'd0)) u_zero (
    .clk(clk), .rstn(rstn), .en(en_s), .data_out(dout_z), .valid(valid_z));
  urng_64 u_def (
    .clk(clk), .rstn(rstn), .en(en_d), .data_out(dout_d), .valid(valid_d));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One Tausworthe component step written from the generic recurrence.
  function automatic logic [63:0] taus(input logic [63:0] s, input int q, input int sh,
                                       input int k, input logic [63:0] mask);
    logic [63:0] b;
    b = ((s << q) ^ s) >> sh;
    return ((s & mask) << k) ^ b;
  endfunction

  typedef struct {
    logic        rstn;
    logic        en;
    logic [63:0] exp_data;
    logic        exp_valid;
  } vec_t;

  localparam logic [63:0] SMP1 = 64'h0000_0200_0000_4800;
  localparam logic [63:0] SMP2 = 64'h0000_0000_000C_0000;

  vec_t vecs[14];

  logic [63:0] m0, m1, m2, my;
  int          ones[64];
  int          n_samp;
  int          n_zero;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 64'd0, 1'b0};  // reset
    vecs[1]  = '{1'b1, 1'b1, SMP1,  1'b1};
    vecs[2]  = '{1'b1, 1'b1, SMP2,  1'b1};
    vecs[3]  = '{1'b0, 1'b0, 64'd0, 1'b0};  // reset, then five idle cycles
    for (int i = 4; i <= 8; i++) vecs[i] = '{1'b1, 1'b0, 64'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, SMP1,  1'b1};
    vecs[10] = '{1'b0, 1'b0, 64'd0, 1'b0};  // reset, then en = 1,0,1
    vecs[11] = '{1'b1, 1'b1, SMP1,  1'b1};
    vecs[12] = '{1'b1, 1'b0, SMP1,  1'b0};
    vecs[13] = '{1'b1, 1'b1, SMP2,  1'b1};

    #1;
    check("reset_data", dout_s, 64'd0);
    check("reset_valid", {63'd0, valid_s}, 64'd0);

    // Directed vectors, applied on the falling edge and sampled after the rising edge.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rstn = vecs[i].rstn;
      en_s = vecs[i].en;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_data", i), dout_s, vecs[i].exp_data);
      check($sformatf("vec%0d_valid", i), {63'd0, valid_s}, {63'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_zero_seed_data", i), dout_z, vecs[i].exp_data);
      check($sformatf("vec%0d_zero_seed_valid", i), {63'd0, valid_z}, {63'd0, vecs[i].exp_valid});
    end

    // Ten enabled samples, then an asynchronous reset in the middle of a cycle.
    @(negedge clk);
    rstn = 1'b0;
    en_s = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    en_s = 1'b1;
    m0 = 64'd2; m1 = 64'd512; m2 = 64'd4096;
    for (int i = 0; i < 10; i++) begin
      m0 = taus(m0, 1, 53, 10, 64'hFFFF_FFFF_FFFF_FFFE);
      m1 = taus(m1, 24, 50, 5, 64'hFFFF_FFFF_FFFF_FE00);
      m2 = taus(m2, 3, 23, 29, 64'hFFFF_FFFF_FFFF_F000);
      @(posedge clk);
    end
    #1;
    check("sample10_before_reset", dout_s, m0 ^ m1 ^ m2);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_data", dout_s, 64'd0);
    check("async_reset_valid", {63'd0, valid_s}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("after_async_reset_sample1", dout_s, SMP1);
    check("after_async_reset_valid", {63'd0, valid_s}, 64'd1);
    @(negedge clk);
    en_s = 1'b0;

    // Default seeds, random enable gaps, compared with the equation model.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    m0 = 64'h0123_4567_89AB_CDEF | 64'd2;
    m1 = 64'hFEDC_BA98_7654_3210 | 64'd512;
    m2 = 64'h0F1E_2D3C_4B5A_6978 | 64'd4096;
    my = 64'd0;
    n_samp = 0;
    n_zero = 0;
    for (int b = 0; b < 64; b++) ones[b] = 0;
    while (n_samp < 8000) begin
      @(negedge clk);
      en_d = ($urandom_range(3) != 0);
      if (en_d) begin
        m0 = taus(m0, 1, 53, 10, 64'hFFFF_FFFF_FFFF_FFFE);
        m1 = taus(m1, 24, 50, 5, 64'hFFFF_FFFF_FFFF_FE00);
        m2 = taus(m2, 3, 23, 29, 64'hFFFF_FFFF_FFFF_F000);
        my = m0 ^ m1 ^ m2;
      end
      @(posedge clk);
      #1;
      check("model_data", dout_d, my);
      check("model_valid", {63'd0, valid_d}, {63'd0, en_d});
      if (en_d) begin
        n_samp++;
        if (dout_d == 64'd0) n_zero++;
        for (int b = 0; b < 64; b++) ones[b] += int'(dout_d[b]);
      end
    end
    en_d = 1'b0;
    check("zero_samples", 64'(n_zero), 64'd0);
    for (int b = 0; b < 64; b++) begin
      n_tests++;
      if (100 * ones[b] < 47 * n_samp || 100 * ones[b] > 53 * n_samp) begin
        n_fail++;
        $display("FAIL ones_fraction bit %0d: got %0d ones of %0d, expected 47%%..53%%",
                 b, ones[b], n_samp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
